// File: rtl/gat_feat_reader.sv
`default_nettype none
// ============================================================================
// gat_feat_reader : sweeps the GAT feature BRAM (port B, byte addressed) onto
// a valid/ready stream. Optional GAT_FEAT_RD_CHECKSUM_EN adds rd_checksum.
// Rev 1.0
// ============================================================================
module gat_feat_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = RD_LATENCY + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic                          rd_start,
  input  logic                          rd_abort,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          m_node_last,
  output logic                          rd_busy,
  output logic                          rd_done,
  output logic [31:0]                   rd_checksum
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FEAT_W  = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam int ENTRY_W = NEW_FEATURE_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                        state;
  logic [NEW_FEATURE_ADDR_W-1:0] word_idx;
  logic [FEAT_W-1:0]             feat_cnt;
  logic [RD_LATENCY-1:0]         sr_vld;
  logic [RD_LATENCY-1:0]         sr_last;
  logic [RD_LATENCY-1:0]         sr_nlast;
  logic [ENTRY_W-1:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              fifo_count;
  logic [CNT_W-1:0]              inflight;
  logic                          issue;
  logic                          issue_last;
  logic                          issue_nlast;
  logic                          push;
  logic                          pop;
  logic                          start_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(sr_vld[i]);
  end

  // Credit: reads in flight plus queued words may never exceed the FIFO size.
  assign issue       = (state == ISSUE) &&
                       (({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_last  = (word_idx == NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1));
  assign issue_nlast = (feat_cnt == FEAT_W'(NUM_FEATURE_OUT - 1));
  assign push        = sr_vld[RD_LATENCY-1];
  assign pop         = m_tvalid & m_tready;
  assign start_ok    = (state == IDLE) && rd_start && gat_ready;

  assign feat_bram_addrb = {word_idx, 2'b00};
  assign m_tvalid        = (fifo_count != '0);
  assign {m_tlast, m_node_last, m_tdata} = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= '0;
      feat_cnt <= '0;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
    end else if (rd_abort) begin
      state    <= IDLE;
      word_idx <= '0;
      feat_cnt <= '0;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= ISSUE;
            word_idx <= '0;
            feat_cnt <= '0;
            rd_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            feat_cnt <= issue_nlast ? '0 : feat_cnt + FEAT_W'(1);
            if (issue_last) begin
              word_idx <= '0;
              state    <= DRAIN;
            end else begin
              word_idx <= word_idx + NEW_FEATURE_ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && m_tlast) begin
            state   <= DONE;
            rd_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency tracker: tags travel with the valid bit to meet the BRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld   <= '0;
      sr_last  <= '0;
      sr_nlast <= '0;
    end else if (rd_abort) begin
      sr_vld   <= '0;
      sr_last  <= '0;
      sr_nlast <= '0;
    end else begin
      sr_vld[0]   <= issue;
      sr_last[0]  <= issue & issue_last;
      sr_nlast[0] <= issue & issue_nlast;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_vld[i]   <= sr_vld[i-1];
        sr_last[i]  <= sr_last[i-1];
        sr_nlast[i] <= sr_nlast[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (rd_abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {sr_last[RD_LATENCY-1], sr_nlast[RD_LATENCY-1], feat_bram_dout};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef GAT_FEAT_RD_CHECKSUM_EN
  logic [31:0] acc_word;
  logic [31:0] csum;

  if (NEW_FEATURE_WIDTH >= 32) begin : g_csum_trunc
    assign acc_word = m_tdata[31:0];
  end else begin : g_csum_zext
    assign acc_word = {{(32-NEW_FEATURE_WIDTH){1'b0}}, m_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (rd_abort || start_ok) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + acc_word;
    end
  end

  assign rd_checksum = csum;
`else
  assign rd_checksum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gat_feat_reader.sv
`default_nettype none
// tb_gat_feat_reader: directed checks of gat_feat_reader, 2 nodes x 4 features,
// BRAM word k = k+100, with a second instance at RD_LATENCY=3.
module tb_gat_feat_reader;

  localparam int W  = 32;
  localparam int AW = 3;

`ifdef GAT_FEAT_RD_CHECKSUM_EN
  localparam logic [31:0] EXP_CSUM = 32'd828;
`else
  localparam logic [31:0] EXP_CSUM = 32'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, gat_ready, rd_start, rd_abort, m_tready;
  logic [AW+1:0] addrb;
  logic [W-1:0]  dout, m_tdata;
  logic          m_tvalid, m_tlast, m_node_last, rd_busy, rd_done;
  logic [31:0]   rd_checksum;

  logic          start3;
  logic [AW+1:0] addrb3;
  logic [W-1:0]  dout3, tdata3;
  logic          tvalid3, tlast3, nlast3, busy3, done3;
  logic [31:0]   csum3;

  gat_feat_reader #(.NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(2), .NUM_FEATURE_OUT(4),
                    .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready), .rd_start(rd_start),
    .rd_abort(rd_abort), .feat_bram_addrb(addrb), .feat_bram_dout(dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_node_last(m_node_last), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_checksum(rd_checksum));

  gat_feat_reader #(.NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(2), .NUM_FEATURE_OUT(4),
                    .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready), .rd_start(start3),
    .rd_abort(1'b0), .feat_bram_addrb(addrb3), .feat_bram_dout(dout3),
    .m_tdata(tdata3), .m_tvalid(tvalid3), .m_tready(1'b1), .m_tlast(tlast3),
    .m_node_last(nlast3), .rd_busy(busy3), .rd_done(done3), .rd_checksum(csum3));

  // BRAM models: word k holds k+100
  always @(posedge clk) dout <= 32'(addrb >> 2) + 32'd100;

  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= 32'(addrb3 >> 2) + 32'd100;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout3 = p3[2];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   got_d[$];
  bit            got_l[$];
  bit            got_n[$];
  logic [31:0]   got3[$];
  logic [AW+1:0] prev_addr;
  logic [AW+1:0] addr_seq[$];
  int accepted, issued, max_out, hold_bad, done_cnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_counts();
    got_d.delete(); got_l.delete(); got_n.delete(); addr_seq.delete();
    accepted = 0; issued = 0; max_out = 0; hold_bad = 0; done_cnt = 0;
    prev_addr = addrb;
  endtask

  // One clock: log what the coming edge accepts, then sample #1 after it.
  task automatic cyc();
    bit          acc, stall;
    logic [W-1:0] hd;
    acc   = (m_tvalid === 1'b1) && (m_tready === 1'b1);
    stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1) && (rd_abort !== 1'b1);
    hd    = m_tdata;
    if (acc) begin
      got_d.push_back(m_tdata);
      got_l.push_back(m_tlast);
      got_n.push_back(m_node_last);
    end
    if (tvalid3 === 1'b1) got3.push_back(tdata3);
    @(posedge clk);
    #1;
    if (acc) accepted++;
    if (addrb !== prev_addr) begin
      issued++;
      addr_seq.push_back(addrb);
      prev_addr = addrb;
    end
    if (issued - accepted > max_out) max_out = issued - accepted;
    if (stall && (m_tvalid !== 1'b1 || m_tdata !== hd)) hold_bad++;
    if (rd_done === 1'b1) done_cnt++;
  endtask

  // Start a frame with a repeating tready pattern; a stray rd_start is pulsed mid-frame.
  task automatic run_frame(input bit [3:0] pat, output int first_v, output int done_at,
                           output int busy_len, output logic [AW+1:0] first_addr);
    first_v = -1; done_at = -1; busy_len = 0;
    reset_counts();
    rd_start = 1'b1;
    m_tready = pat[0];
    cyc();
    rd_start = 1'b0;
    first_addr = addrb;
    for (int n = 0; n < 100; n++) begin
      if (first_v < 0 && m_tvalid === 1'b1) first_v = n;
      if (done_at < 0 && rd_done === 1'b1) done_at = n;
      if (rd_busy !== 1'b1) break;
      busy_len++;
      rd_start = (n == 3);
      m_tready = pat[(n + 1) % 4];
      cyc();
    end
    rd_start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    logic [33:0] g;
    check_val({tag, "_count"}, got_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      g = (i < got_d.size()) ? {got_d[i], got_l[i], got_n[i]} : '1;
      check_val($sformatf("%s_w%0d", tag, i), g, {32'(100 + i), i == 7, (i % 4) == 3});
    end
    check_val({tag, "_nseq"}, addr_seq.size(), 8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("%s_addr%0d", tag, i),
                (i < addr_seq.size()) ? 64'(addr_seq[i]) : 64'hFF,
                (i < 7) ? 64'(4 * (i + 1)) : 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_v, done_at, busy_len, first3;
    logic [AW+1:0] first_addr;

    rst_n = 1'b0; gat_ready = 1'b0; rd_start = 1'b0; rd_abort = 1'b0;
    m_tready = 1'b1; start3 = 1'b0;
    reset_counts();
    cyc(); cyc();
    check_val("rst_addrb", addrb, 0);
    check_val("rst_tdata", m_tdata, 0);
    check_val("rst_flags", {m_tvalid, m_tlast, m_node_last, rd_busy, rd_done}, 0);
    check_val("rst_csum", rd_checksum, 0);
    rst_n = 1'b1;
    cyc(); cyc();

    // start without gat_ready is ignored
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    cyc();
    check_val("gate_busy", rd_busy, 0);
    check_val("gate_addrb", addrb, 0);

    // baseline, tready held high
    gat_ready = 1'b1;
    run_frame(4'b1111, first_v, done_at, busy_len, first_addr);
    check_frame("base");
    check_val("base_first_addr", first_addr, 0);
    check_val("base_first_valid", first_v, 2);
    check_val("base_done_at", done_at, 10);
    check_val("base_frame_len", busy_len, 11);
    check_val("base_done_cnt", done_cnt, 1);
    check_val("base_csum", rd_checksum, EXP_CSUM);
    cyc(); cyc();

    // backpressure 1-0-0-1
    run_frame(4'b1001, first_v, done_at, busy_len, first_addr);
    check_frame("bp");
    check_val("bp_hold", hold_bad, 0);
    check_val("bp_credit", max_out <= 3, 1);
    check_val("bp_done_cnt", done_cnt, 1);
    check_val("bp_csum", rd_checksum, EXP_CSUM);
    cyc(); cyc();

    // abort after 3 accepted words while stalled
    reset_counts();
    rd_start = 1'b1;
    m_tready = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int n = 0; n < 40 && accepted < 3; n++) cyc();
    m_tready = 1'b0;
    cyc(); cyc();
    check_val("abort_pre_valid", m_tvalid, 1);
    rd_abort = 1'b1;
    cyc();
    rd_abort = 1'b0;
    check_val("abort_valid", m_tvalid, 0);
    check_val("abort_busy", rd_busy, 0);
    check_val("abort_csum", rd_checksum, 0);
    m_tready = 1'b1;
    for (int n = 0; n < 15; n++) cyc();
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_words", got_d.size(), 3);

    run_frame(4'b1111, first_v, done_at, busy_len, first_addr);
    check_frame("restart");
    check_val("restart_first_addr", first_addr, 0);
    cyc(); cyc();

    // RD_LATENCY = 3 instance
    got3.delete();
    first3 = -1;
    start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (first3 < 0 && tvalid3 === 1'b1) first3 = n;
      if (done3 === 1'b1) break;
      cyc();
    end
    check_val("lat3_first_valid", first3, 4);
    check_val("lat3_count", got3.size(), 8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("lat3_w%0d", i), (i < got3.size()) ? got3[i] : 32'hFFFF_FFFF,
                32'(100 + i));
    cyc(); cyc();

    // asynchronous reset mid-frame
    reset_counts();
    rd_start = 1'b1;
    m_tready = 1'b0;
    cyc();
    rd_start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    check_val("arst_pre", {rd_busy, m_tvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_addrb", addrb, 0);
    check_val("arst_tdata", m_tdata, 0);
    check_val("arst_flags", {m_tvalid, m_tlast, m_node_last, rd_busy, rd_done}, 0);
    check_val("arst_csum", rd_checksum, 0);
    #3 rst_n = 1'b1;
    m_tready = 1'b1;
    cyc(); cyc();
    check_val("arst_idle", {rd_busy, m_tvalid, addrb}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
